// File: rtl/pwm_mixer_dac.sv
// pwm_mixer_dac
//   Sums three unsigned channel volume words and turns the sum into a single
//   1-bit pulse stream for an off-chip RC filter. The sum is registered and
//   quantised to its top PWM_BITS bits to give a duty value. That value is
//   loaded only at period boundaries, so a volume change never alters the
//   pulse width of a period already in progress.
//
//   Parameters
//     VOLUME_BITS  width of each channel volume input (default 15)
//     PWM_BITS     width of the period counter; period = 2**PWM_BITS clocks
//
//   Ports
//     clk       system clock, rising edge
//     rst_n     synchronous active-low reset
//     en        run enable; low parks the modulator (counter at MAX, duty 0)
//     vol_a/b/c channel volume levels (unsigned)
//     pwm_o     registered pulse stream to the pad
//     period_o  one-cycle strobe: new duty loaded, counter at 0
//     duty_o    currently latched duty value (debug / test visibility)
//
//   There is no valid/ready handshake: the volume words are level inputs
//   sampled on every clock edge.
//
//   Build option
//     SIGMA_DELTA_EN  when defined, the comparator output stage is replaced by
//                     a first-order delta-sigma modulator driven by the same
//                     latched duty value. Undefined: plain comparator PWM.
module pwm_mixer_dac #(
  parameter int VOLUME_BITS = 15,
  parameter int PWM_BITS    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [VOLUME_BITS-1:0] vol_a,
  input  logic [VOLUME_BITS-1:0] vol_b,
  input  logic [VOLUME_BITS-1:0] vol_c,
  output logic                   pwm_o,
  output logic                   period_o,
  output logic [PWM_BITS-1:0]    duty_o
);

  // Two extra bits hold the sum of three full-scale words without overflow.
  localparam int SUM_BITS = VOLUME_BITS + 2;
  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

  logic [SUM_BITS-1:0] sum_q;
  logic [PWM_BITS-1:0] cnt;
  logic [PWM_BITS-1:0] duty_q;
  logic [PWM_BITS-1:0] duty_next;
  logic                at_max;

  // Quantiser: keep the top PWM_BITS bits of the sum, truncating.
  assign duty_next = sum_q[SUM_BITS-1 -: PWM_BITS];
  assign at_max    = (cnt == CNT_MAX);
  assign duty_o    = duty_q;

`ifdef SIGMA_DELTA_EN
  logic [PWM_BITS-1:0] acc;
  logic [PWM_BITS:0]   sd_sum;

  // The carry out of the accumulator is the modulator output bit.
  always_comb begin
    sd_sum = {1'b0, acc} + {1'b0, duty_q};
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q    <= '0;
      cnt      <= CNT_MAX;
      duty_q   <= '0;
      pwm_o    <= 1'b0;
      period_o <= 1'b0;
`ifdef SIGMA_DELTA_EN
      acc      <= '0;
`endif
    end else begin
      // The sum stage runs regardless of the enable.
      sum_q <= {2'b00, vol_a} + {2'b00, vol_b} + {2'b00, vol_c};

      if (!en) begin
        // Parked: counter sits at MAX so the first enabled edge is a load.
        cnt      <= CNT_MAX;
        duty_q   <= '0;
        pwm_o    <= 1'b0;
        period_o <= 1'b0;
`ifdef SIGMA_DELTA_EN
        acc      <= '0;
`endif
      end else begin
        cnt      <= cnt + PWM_BITS'(1);
        period_o <= at_max;
        if (at_max) begin
          duty_q <= duty_next;
        end
`ifdef SIGMA_DELTA_EN
        // Accumulator runs freely across period boundaries.
        acc   <= sd_sum[PWM_BITS-1:0];
        pwm_o <= sd_sum[PWM_BITS];
`else
        // cnt==MAX never compares below duty_q, so the load cycle is low and
        // the high run starts the cycle after period_o.
        pwm_o <= (cnt < duty_q);
`endif
      end
    end
  end

endmodule
